counting_grade: RTL and testbench
=================================

Name: counting_grade

Overview:
Scoreboard for a two-player rock-paper-scissors game.
- On each round strobe it compares the left (player A) and right (player B) gestures, decides the winner and increments that player's 3-bit score.
- Sits after the gesture-capture logic and feeds the score display.
- Clearing both scores starts a new match.

Parameters:
MAX_SCORE, 7, saturation/match-end value for either score (1..7).

Ports:
start_pulse  input  1  round strobe; scoring clock; all state updates on its rising edge
sw2  input  1  clear; asynchronous, active-high; zeroes both scores
left  input  3  player A gesture, one-hot
right  input  3  player B gesture, one-hot
a_score  output  3  player A score
b_score  output  3  player B score

Positional port order is fixed: start_pulse, left, right, a_score, b_score, sw2.

Behaviour:
- Gesture encoding:
  - 3'b001 = rock
  - 3'b010 = paper
  - 3'b100 = scissors
  - Any other code (including 3'b000) is invalid.
- Win rules: rock beats scissors, scissors beats paper, paper beats rock. Equal gestures are a draw.
- Reset/clear:
  - While sw2=1, a_score=0 and b_score=0 immediately, with no clock needed.
  - Rising edges of start_pulse have no effect while sw2=1.
  - sw2 asserted mid-match discards all progress.
- Each rising edge of start_pulse with sw2=0 is one round:
  - A wins: a_score <= a_score+1, b_score unchanged.
  - B wins: b_score <= b_score+1, a_score unchanged.
  - Draw: both scores unchanged.
  - Either gesture invalid: both scores unchanged.
- Latency: a score updates on the same rising edge that samples left/right. Outputs are registered and glitch-free.
- left/right must be stable around the rising edge. They may change freely between edges.
- Saturation/match end:
  - Once either score equals MAX_SCORE, both scores freeze until sw2 is asserted.
  - A score never wraps past 7.
- At most one score changes per round. A and B can never both increment in the same edge.
- No other outputs and no internal state beyond the two score registers and the derived frozen condition.

Test Plan:
- Clear and invalid round:
  - Stimulus: sw2=1 at t=0, then deassert; round with left=000, right=000.
  - Required: a_score=0, b_score=0.
- Full sequence (MAX_SCORE=7, edges after clear):
  - Rounds, in order: 001/010, then 010/001, then 001/100, then 100/100.
  - Required scores (a/b) after each round: 0/1, 1/1, 2/1, 2/1 (the last round is a draw).
- Asynchronous clear:
  - Stimulus: from 2/1, raise sw2 between edges.
  - Required: both scores 0 immediately. A round edge with sw2 held high leaves them 0.
- All nine valid pairings:
  - A wins: rock/scissors, paper/rock, scissors/paper.
  - B wins: the mirrored pairings.
  - Draw: the three equal pairings; no change.
- Invalid codes:
  - Stimulus: left=011, right=001; and left=001, right=110.
  - Required: no score change.
- Saturation:
  - Stimulus: seven A wins, then an eighth A win and one B win.
  - Required: a_score=7, b_score stays 0 (frozen). After sw2 pulse, both 0 and scoring resumes.

Source files
------------

// File: rtl/counting_grade.sv
// Rock-paper-scissors scoreboard: each start_pulse edge scores one round and
// both scores freeze at MAX_SCORE until sw2 clears them.
module counting_grade #(
  parameter int unsigned MAX_SCORE = 7
) (
  input  logic       start_pulse,
  input  logic [2:0] left,
  input  logic [2:0] right,
  output logic [2:0] a_score,
  output logic [2:0] b_score,
  input  logic       sw2
);

  typedef enum logic [2:0] {
    ROCK     = 3'b001,
    PAPER    = 3'b010,
    SCISSORS = 3'b100
  } gesture_e;

  localparam logic [2:0] MAX_VAL = 3'(MAX_SCORE);

  logic [2:0] r_a_score;
  logic [2:0] r_b_score;
  logic       w_valid;
  logic       w_a_wins;
  logic       w_b_wins;
  logic       w_frozen;

  function automatic logic is_gesture(input logic [2:0] g);
    return (g == ROCK) || (g == PAPER) || (g == SCISSORS);
  endfunction

  function automatic logic beats(input logic [2:0] x, input logic [2:0] y);
    return ((x == ROCK)     && (y == SCISSORS)) ||
           ((x == SCISSORS) && (y == PAPER))    ||
           ((x == PAPER)    && (y == ROCK));
  endfunction

  // NOTE: every signal driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    w_valid  = 1'b0;
    w_a_wins = 1'b0;
    w_b_wins = 1'b0;
    w_frozen = (r_a_score == MAX_VAL) || (r_b_score == MAX_VAL);
    w_valid  = is_gesture(left) && is_gesture(right);
    if (w_valid) begin
      w_a_wins = beats(left, right);
      w_b_wins = beats(right, left);
    end
  end

  // NOTE: state uses non-blocking assignments so both scores update from the
  // same pre-edge values, independent of statement order.
  always_ff @(posedge start_pulse or posedge sw2) begin
    if (sw2) begin
      r_a_score <= 3'd0;
      r_b_score <= 3'd0;
    end else if (!w_frozen) begin
      // beats() is antisymmetric, so at most one of these is ever set
      if (w_a_wins) begin
        r_a_score <= r_a_score + 3'd1;
      end else if (w_b_wins) begin
        r_b_score <= r_b_score + 3'd1;
      end
    end
  end

  assign a_score = r_a_score;
  assign b_score = r_b_score;

endmodule

// File: tb/tb_counting_grade.sv
// Directed bench for counting_grade: hand-computed scores after each round,
// covering clear, all pairings, invalid codes and saturation at MAX_SCORE=7.
module tb_counting_grade;

  logic       start_pulse;
  logic       sw2;
  logic [2:0] left;
  logic [2:0] right;
  logic [2:0] a_score;
  logic [2:0] b_score;

  int n_checks = 0;
  int n_errors = 0;

  counting_grade #(.MAX_SCORE(7)) dut (
    .start_pulse (start_pulse),
    .left        (left),
    .right       (right),
    .a_score     (a_score),
    .b_score     (b_score),
    .sw2         (sw2)
  );

  task automatic check(input string tag, input logic [2:0] exp_a, input logic [2:0] exp_b);
    n_checks++;
    assert ({a_score, b_score} === {exp_a, exp_b})
    else begin
      n_errors++;
      $error("FAIL %s: a/b=%0d/%0d expected %0d/%0d", tag, a_score, b_score, exp_a, exp_b);
    end
  endtask

  // One round: inputs set well before the edge, outputs sampled 5 units after it.
  task automatic round(input logic [2:0] l, input logic [2:0] r);
    left  = l;
    right = r;
    #5 start_pulse = 1'b1;
    #5 start_pulse = 1'b0;
  endtask

  task automatic clear_pulse();
    #2 sw2 = 1'b1;
    #2 sw2 = 1'b0;
    #1;
  endtask

  initial begin
    start_pulse = 1'b0;
    sw2         = 1'b1;
    left        = 3'b000;
    right       = 3'b000;
    #1 check("reset", 3'd0, 3'd0);
    #4 sw2 = 1'b0;

    round(3'b000, 3'b000); check("invalid_zero", 3'd0, 3'd0);

    round(3'b001, 3'b010); check("seq_rock_paper",      3'd0, 3'd1);
    round(3'b010, 3'b001); check("seq_paper_rock",      3'd1, 3'd1);
    round(3'b001, 3'b100); check("seq_rock_scissors",   3'd2, 3'd1);
    round(3'b100, 3'b100); check("seq_draw",            3'd2, 3'd1);

    // Clear between edges must act without any clock edge
    #2 sw2 = 1'b1;
    #1 check("async_clear", 3'd0, 3'd0);
    round(3'b001, 3'b100); check("edge_during_clear", 3'd0, 3'd0);
    #2 sw2 = 1'b0;
    #1;

    round(3'b001, 3'b100); check("a_rock_scissors",  3'd1, 3'd0);
    round(3'b010, 3'b001); check("a_paper_rock",     3'd2, 3'd0);
    round(3'b100, 3'b010); check("a_scissors_paper", 3'd3, 3'd0);
    round(3'b100, 3'b001); check("b_rock_scissors",  3'd3, 3'd1);
    round(3'b001, 3'b010); check("b_paper_rock",     3'd3, 3'd2);
    round(3'b010, 3'b100); check("b_scissors_paper", 3'd3, 3'd3);
    round(3'b001, 3'b001); check("draw_rock",        3'd3, 3'd3);
    round(3'b010, 3'b010); check("draw_paper",       3'd3, 3'd3);
    round(3'b100, 3'b100); check("draw_scissors",    3'd3, 3'd3);

    round(3'b011, 3'b001); check("invalid_left",  3'd3, 3'd3);
    round(3'b001, 3'b110); check("invalid_right", 3'd3, 3'd3);
    round(3'b111, 3'b100); check("invalid_all",   3'd3, 3'd3);

    clear_pulse(); check("clear_pulse", 3'd0, 3'd0);
    for (int i = 1; i <= 7; i++) begin
      round(3'b010, 3'b001);
      check($sformatf("a_win_%0d", i), 3'(i), 3'd0);
    end
    round(3'b010, 3'b001); check("a_frozen_8th", 3'd7, 3'd0);
    round(3'b001, 3'b010); check("b_frozen",     3'd7, 3'd0);

    clear_pulse(); check("clear_after_sat", 3'd0, 3'd0);
    round(3'b001, 3'b010); check("resume_b", 3'd0, 3'd1);
    round(3'b100, 3'b010); check("resume_a", 3'd1, 3'd1);

    clear_pulse();
    for (int i = 1; i <= 7; i++) begin
      round(3'b100, 3'b001);
    end
    check("b_saturated", 3'd0, 3'd7);
    round(3'b001, 3'b100); check("a_frozen_by_b", 3'd0, 3'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
